// File: rtl/lcd_write_number.sv
// lcd_write_number: HD44780 4-bit LCD driver that runs power-on init and configuration,
// then shows each accepted 32-bit value as 8 uppercase hex characters at line 1, column 0.
module lcd_write_number #(
  parameter int T_POWERUP    = 750000,
  parameter int T_4100US     = 205000,
  parameter int T_100US      = 5000,
  parameter int T_40US       = 2000,
  parameter int T_1640US     = 82000,
  parameter int T_E_HIGH     = 12,
  parameter int T_NIBBLE_GAP = 50
) (
  input  logic        CLK_50MHZ,
  input  logic        RST_N,
  input  logic [31:0] if_data,
  input  logic        if_write,
  output logic        if_ready,
  output logic        LCD_E,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic [3:0]  LCD_D
);
  typedef enum logic [2:0] {S_POWER, S_SETUP, S_PULSE, S_WAIT, S_IDLE} state_t;
  // Init/config nibbles, step 0 in the low nibble: 3,3,3,2 then 0x28,0x06,0x0C,0x01
  localparam logic [47:0] INIT_NIB = 48'h10C0_6082_2333;
  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d, wait_c;
  logic [4:0]  step_q, step_d;
  logic [3:0]  idx, nib, nib_c, d_q, d_d;
  logic [7:0]  ascii;
  logic [31:0] data_q, data_d;
  logic        xfer_q, xfer_d, e_q, e_d, rs_q, rs_d, rdy_q, rdy_d, rs_c, last_c;

  assign if_ready = rdy_q;
  assign LCD_E    = e_q;
  assign LCD_RS   = rs_q;
  assign LCD_D    = d_q;
  assign LCD_RW   = 1'b0;

  // Transfer steps: 0,1 carry the 0x80 address command; steps 2..17 are hex chars, MS nibble first
  always_comb begin
    idx    = step_q[3:0] - 4'd2;
    nib    = data_q[{~idx[3:1], 2'b00} +: 4];
    ascii  = (nib < 4'd10) ? {4'h3, nib} : {4'h4, nib - 4'd9};
    rs_c   = xfer_q & (step_q > 5'd1);
    nib_c  = !xfer_q ? INIT_NIB[{step_q[3:0], 2'b00} +: 4] :
             step_q == 5'd0 ? 4'h8 : step_q == 5'd1 ? 4'h0 :
             idx[0] ? ascii[3:0] : ascii[7:4];
    wait_c = (!xfer_q && step_q == 5'd0)  ? 20'(T_4100US) :
             (!xfer_q && step_q == 5'd1)  ? 20'(T_100US) :
             (!xfer_q && step_q == 5'd11) ? 20'(T_40US + T_1640US) :
             ((!xfer_q && step_q < 5'd4) || step_q[0]) ? 20'(T_40US) : 20'(T_NIBBLE_GAP);
    last_c = step_q == (xfer_q ? 5'd17 : 5'd11);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 20'd1;
    step_d  = step_q;
    xfer_d  = xfer_q;
    e_d     = e_q;
    rs_d    = rs_q;
    d_d     = d_q;
    rdy_d   = rdy_q;
    data_d  = data_q;
    case (state_q)
      S_POWER: if (cnt_q == 20'(T_POWERUP - 1)) begin
        state_d = S_SETUP;
        cnt_d   = '0;
      end
      S_SETUP: begin
        if (cnt_q == 20'd0) begin
          rs_d = rs_c;
          d_d  = nib_c;
        end
        if (cnt_q == 20'd2) begin
          state_d = S_PULSE;
          cnt_d   = '0;
          e_d     = 1'b1;
        end
      end
      S_PULSE: if (cnt_q == 20'(T_E_HIGH - 1)) begin
        state_d = S_WAIT;
        cnt_d   = '0;
        e_d     = 1'b0;
      end
      S_WAIT: if (cnt_q == wait_c - 20'd1) begin
        cnt_d   = '0;
        step_d  = last_c ? 5'd0 : step_q + 5'd1;
        state_d = last_c ? S_IDLE : S_SETUP;
        rdy_d   = last_c;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (if_write) begin
          state_d = S_SETUP;
          data_d  = if_data;
          xfer_d  = 1'b1;
          rdy_d   = 1'b0;
        end
      end
      default: state_d = S_POWER;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_POWER;
      cnt_q   <= '0;
      step_q  <= '0;
      xfer_q  <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      d_q     <= '0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      xfer_q  <= xfer_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      d_q     <= d_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_lcd_write_number.sv
// tb_lcd_write_number: directed bench for the LCD hex-number driver with shortened timings.
module tb_lcd_write_number;
  localparam int P = 100, T4100 = 40, T100 = 20, T40 = 15, T1640 = 30, EH = 4, GAP = 5;
  localparam logic [47:0] INIT_EXP = 48'h10C0_6082_2333;

  logic        clk = 1'b0, rst_n = 1'b0, if_write = 1'b0;
  logic [31:0] if_data = '0;
  logic        if_ready, e, rs, rw;
  logic [3:0]  d;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  lcd_write_number #(
    .T_POWERUP(P), .T_4100US(T4100), .T_100US(T100), .T_40US(T40),
    .T_1640US(T1640), .T_E_HIGH(EH), .T_NIBBLE_GAP(GAP)
  ) dut (
    .CLK_50MHZ(clk), .RST_N(rst_n), .if_data(if_data), .if_write(if_write),
    .if_ready(if_ready), .LCD_E(e), .LCD_RS(rs), .LCD_RW(rw), .LCD_D(d)
  );

  // Bus monitor: records {RS,D} at each E rise, E widths and protocol violations
  logic [4:0] nq[$];
  int         wq[$];
  int         cyc = 0, viol = 0, w = 0, first_rise = -1, rst_cyc = 0, rdy_rise = 0, last_fall = 0;
  logic       pe = 1'b0, prdy = 1'b0;
  logic [4:0] h1 = '0, h2 = '0, cur = '0;
  always @(negedge clk) begin
    cyc++;
    if (rw !== 1'b0) viol++;
    if (!rst_n) begin
      pe = 1'b0; prdy = 1'b0; first_rise = -1; rst_cyc = cyc;
    end else begin
      if (e && !pe) begin
        cur = {rs, d};
        if (cur !== h1 || h1 !== h2) viol++;
        nq.push_back(cur);
        w = 1;
        if (first_rise < 0) first_rise = cyc;
      end else if (e) begin
        w++;
        if ({rs, d} !== cur) viol++;
      end else if (pe) begin
        wq.push_back(w);
        last_fall = cyc;
        if ({rs, d} !== cur) viol++;
      end
      if (if_ready && !prdy) rdy_rise = cyc;
      pe = e; prdy = if_ready;
    end
    h2 = h1; h1 = {rs, d};
  end

  function automatic logic [4:0] exp_nib(input logic [63:0] asc, input int k);
    logic [7:0] b;
    if (k == 0) return 5'h08;
    if (k == 1) return 5'h00;
    b = asc[63 - 8 * ((k - 2) / 2) -: 8];
    return {1'b1, ((k - 2) % 2) ? b[3:0] : b[7:4]};
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (if_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    nq.delete(); wq.delete(); viol = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({e, rs, rw, d} !== 7'd0) begin errors++; $display("FAIL reset_pins: got %b expected 0000000", {e, rs, rw, d}); end
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", if_ready); end
    clear_mon();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL post_release_ready: got %b expected 0", if_ready); end
  endtask

  task automatic test_init(input string tag);
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_ready_timeout: got 0 expected 1", tag); end
    checks++;
    if (first_rise - rst_cyc < P) begin errors++; $display("FAIL %s_powerup: got %0d cycles expected >= %0d", tag, first_rise - rst_cyc, P); end
    checks++;
    if (nq.size() != 12) begin errors++; $display("FAIL %s_count: got %0d expected 12", tag, nq.size()); end
    for (int i = 0; i < 12 && i < nq.size(); i++) begin
      checks++;
      if (nq[i] !== {1'b0, INIT_EXP[i*4 +: 4]}) begin
        errors++; $display("FAIL %s_nib[%0d]: got %h expected %h", tag, i, nq[i], {1'b0, INIT_EXP[i*4 +: 4]});
      end
    end
    foreach (wq[i]) begin
      checks++;
      if (wq[i] != EH) begin errors++; $display("FAIL %s_e_width[%0d]: got %0d expected %0d", tag, i, wq[i], EH); end
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL %s_bus_stability: got %0d violations expected 0", tag, viol); end
    checks++;
    if (rdy_rise - last_fall != T40 + T1640) begin
      errors++; $display("FAIL %s_clear_wait: got %0d expected %0d", tag, rdy_rise - last_fall, T40 + T1640);
    end
  endtask

  task automatic test_write_held();
    bit ok;
    logic [63:0] asc = 64'h4142424130313234;
    clear_mon();
    if_data = 32'hABBA0124; if_write = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL held_ready_drop: got %b expected 0", if_ready); end
    @(posedge clk); #1;
    if_write = 1'b0;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL held_ready_timeout: got 0 expected 1"); end
    repeat (60) @(negedge clk);
    checks++;
    if (nq.size() != 18) begin errors++; $display("FAIL held_count: got %0d expected 18", nq.size()); end
    for (int k = 0; k < 18 && k < nq.size(); k++) begin
      checks++;
      if (nq[k] !== exp_nib(asc, k)) begin errors++; $display("FAIL held_nib[%0d]: got %h expected %h", k, nq[k], exp_nib(asc, k)); end
    end
    foreach (wq[i]) begin
      checks++;
      if (wq[i] != EH) begin errors++; $display("FAIL held_e_width[%0d]: got %0d expected %0d", i, wq[i], EH); end
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL held_bus_stability: got %0d violations expected 0", viol); end
    checks++;
    if (rdy_rise - last_fall != T40) begin errors++; $display("FAIL held_final_wait: got %0d expected %0d", rdy_rise - last_fall, T40); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    logic [63:0] asc_f = 64'h4646464646464646, asc_0 = 64'h3030303030303030;
    clear_mon();
    if_data = 32'hFFFFFFFF; if_write = 1'b1;
    @(posedge clk); #1;
    if_data = 32'h00000000;
    wait_ready(ok1);
    if_write = 1'b0;
    wait_ready(ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_ready_timeout: got %b%b expected 11", ok1, ok2); end
    checks++;
    if (nq.size() != 36) begin errors++; $display("FAIL b2b_count: got %0d expected 36", nq.size()); end
    for (int k = 0; k < 36 && k < nq.size(); k++) begin
      checks++;
      if (nq[k] !== exp_nib(k < 18 ? asc_f : asc_0, k % 18)) begin
        errors++; $display("FAIL b2b_nib[%0d]: got %h expected %h", k, nq[k], exp_nib(k < 18 ? asc_f : asc_0, k % 18));
      end
    end
  endtask

  task automatic test_ignored();
    bit ok;
    logic [63:0] asc = 64'h3941334335453744;
    clear_mon();
    if_data = 32'h9A3C5E7D; if_write = 1'b1;
    @(posedge clk); #1;
    if_write = 1'b0;
    for (int i = 0; i < 2000 && nq.size() < 6; i++) @(negedge clk);
    checks++;
    if (nq.size() < 6) begin errors++; $display("FAIL ign_progress_timeout: got %0d expected >= 6", nq.size()); end
    @(posedge clk); #1;
    if_data = 32'h12345678; if_write = 1'b1;
    @(posedge clk); #1;
    if_write = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    if_write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if_write = 1'b0;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ign_ready_timeout: got 0 expected 1"); end
    repeat (60) @(negedge clk);
    checks++;
    if (nq.size() != 18) begin errors++; $display("FAIL ign_count: got %0d expected 18", nq.size()); end
    for (int k = 0; k < 18 && k < nq.size(); k++) begin
      checks++;
      if (nq[k] !== exp_nib(asc, k)) begin errors++; $display("FAIL ign_nib[%0d]: got %h expected %h", k, nq[k], exp_nib(asc, k)); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    clear_mon();
    if_data = 32'h00000001; if_write = 1'b1;
    @(posedge clk); #1;
    if_write = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = e && nq.size() >= 4;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_e_timeout: got 0 expected 1"); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({e, rs, d, if_ready} !== 7'd0) begin errors++; $display("FAIL mid_async_clear: got %b expected 0000000", {e, rs, d, if_ready}); end
    repeat (3) @(posedge clk);
    #1;
    clear_mon();
    rst_n = 1'b1;
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_write_held();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_write_number.md
Name: lcd_write_number

Overview:
- Drives the Spartan-3E starter-kit character LCD (HD44780-compatible, 4-bit bus, write-only) from a 50 MHz clock.
- After reset it runs the LCD power-on initialisation and configuration sequence.
- It then accepts 32-bit values through a ready/write handshake and shows each value as 8 uppercase hex characters at line 1, column 0.
- Sits between user logic and the LCD pins.

Parameters:
- T_POWERUP, 750000: cycles of power-on wait (15 ms).
- T_4100US, 205000: wait after first 0x3 init nibble (4.1 ms).
- T_100US, 5000: wait after second 0x3 init nibble (100 us).
- T_40US, 2000: wait after third init nibble, after the 0x2 nibble, and after every full byte (40 us).
- T_1640US, 82000: extra wait after the Clear Display command (1.64 ms).
- T_E_HIGH, 12: LCD_E high width in cycles (240 ns).
- T_NIBBLE_GAP, 50: cycles from end of upper-nibble E pulse to start of lower-nibble setup (1 us).

Ports:
- CLK_50MHZ  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- if_data  in  32  value to display; sampled on the accepted write.
- if_write  in  1  write request; may be held for several cycles.
- if_ready  out  1  high when idle and able to accept a write.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  0 = command, 1 = data.
- LCD_RW  out  1  constant 0 (write only).
- LCD_D  out  4  LCD data nibble (SF_D[11:8]).

Behaviour:
- Reset (RST_N=0, async): LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_D=0, if_ready=0, all counters cleared, FSM returns to power-up wait. Reset mid-operation aborts and restarts full init on release.
- Nibble write: drive LCD_RS/LCD_D; hold 2 cycles setup with E=0; E=1 for T_E_HIGH cycles; E=0; hold RS/D for at least 1 more cycle.
- Byte write: upper nibble, wait T_NIBBLE_GAP, lower nibble, wait T_40US.
- Init sequence, RS=0, single nibbles:
  - wait T_POWERUP
  - 0x3, wait T_4100US
  - 0x3, wait T_100US
  - 0x3, wait T_40US
  - 0x2, wait T_40US
- Configuration bytes, RS=0:
  - 0x28 (function set)
  - 0x06 (entry mode)
  - 0x0C (display on, cursor off)
  - 0x01 (clear), then an additional T_1640US wait
- After configuration, if_ready=1 (IDLE).
- Accept rule: in IDLE, if_write=1 on a rising edge latches if_data and drives if_ready=0 on the next cycle.
  - Any if_write while if_ready=0 is ignored; no queuing.
  - A write still held after the transfer completes starts a new transfer.
- Display transfer:
  - Command byte 0x80 (set DDRAM address 0), RS=0.
  - Then 8 data bytes, RS=1, nibble 7 (bits 31:28) first down to nibble 0.
  - Encoding: 0–9 -> 0x30–0x39; A–F -> 0x41–0x46.
  - After the final byte's T_40US wait, if_ready returns to 1.
- LCD_D and LCD_RS change only while LCD_E=0.

Test Plan:
- Reset, then release RST_N -> if_ready=0. First E pulse starts no earlier than T_POWERUP cycles with LCD_D=0x3, RS=0. Init nibbles in order: 3,3,3,2. Config nibbles: 2,8,0,6,0,C,0,1. if_ready rises only after the clear wait.
- Any E pulse -> LCD_E high exactly T_E_HIGH cycles. LCD_D/RS stable from 2 cycles before rise until 1 cycle after fall. LCD_RW=0 throughout.
- if_ready=1, if_write held 2 cycles with 0xABBA0124 -> exactly one transfer. Nibbles: RS=0: 8,0; RS=1: 4,1,4,2,4,2,4,1,3,0,3,1,3,2,3,4 (shows "ABBA0124"). if_ready back to 1 after last T_40US.
- Write 0xFFFFFFFF, then 0x00000000 -> data bytes all 0x46, then all 0x30.
- Pulse if_write with 0x12345678 during a transfer -> ignored; the displayed value is unchanged.
- Assert RST_N=0 mid-transfer -> outputs clear immediately. After release, full init sequence repeats before if_ready=1.
